ret_shadow_stack: RTL and testbench
===================================

Name: ret_shadow_stack

Overview:
- Shadow return-address stack that sequences control-flow integrity checks for the branch unit.
- Records the plain link address on every call (JAL/JALR with rd=x1) and checks every return (JALR rd=x0, rs1=x1) against the top entry.
- Raises a sticky crash request that the branch unit uses to force the redirect target to zero.
- Sits beside the branch unit in EX; fed from the resolved-branch path, one event per cycle.

Parameters:
- DEPTH, 16, number of shadow entries (power of two, ≥2).
- VLEN, riscv::VLEN, address width.
- DROP_W, 8, width of the overflow-drop counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  checking enabled (en_crash); when low, the stack still tracks but never flags
- flush_i  in  1  empty the stack (context switch / fence); does not clear crash
- call_valid_i  in  1  resolved call this cycle
- call_link_i  in  VLEN  plain (un-encoded) next_pc of the call
- ret_valid_i  in  1  resolved return this cycle
- ret_target_i  in  VLEN  decoded return target, bit 0 cleared
- crash_clr_i  in  1  debug/software clear of sticky crash
- mismatch_o  out  1  one-cycle pulse: return violation detected
- crash_o  out  1  sticky crash request
- depth_o  out  $clog2(DEPTH)+1  current valid entries
- dropped_o  out  DROP_W  entries lost to overflow, not yet unwound

Behaviour:
- Reset: all outputs 0; sp=0; dropped=0; FSM=RUN; storage contents don't-care.
- Storage: circular buffer of DEPTH×VLEN, write pointer wp, count cnt.
- Call: store call_link_i at wp; wp++ (wraps modulo DEPTH); cnt++.
- Call while full: overwrite oldest; cnt stays DEPTH; dropped++ (saturates at all-ones).
- Return with cnt>0:
  - Compare ret_target_i to entry wp-1; wp--; cnt--.
  - Result is registered: mismatch_o asserts the cycle after ret_valid_i (latency 1).
- Return with cnt==0 and dropped>0: no check; dropped--.
- Return with cnt==0 and dropped==0: underflow, counts as a violation.
- Violation (mismatch or underflow) with en_i=1:
  - mismatch_o pulses one cycle.
  - FSM RUN→CRASH; crash_o=1 from the same cycle mismatch_o rises.
- Violations with en_i=0: stack still updates; no pulse, no FSM change.
- FSM:
  - RUN: normal operation.
  - CRASH: crash_o=1; calls and returns are ignored (stack frozen); exits to RUN only on crash_clr_i, which also empties the stack.
  - FLUSH: entered from RUN on flush_i. Takes one cycle: cnt=0, wp=0, dropped=0; any pending compare result is discarded (no pulse). Then returns to RUN. Events arriving in the FLUSH cycle are ignored.
- Simultaneous call_valid_i and ret_valid_i:
  - Return is processed first (compare against the top), then the call pushes into the freed slot.
  - cnt is unchanged; dropped is not incremented even when full.
- flush_i together with an event: flush wins; the event is dropped.
- rst_i mid-operation: immediate return to reset state next edge; a pending mismatch pulse is suppressed.
- crash_clr_i in RUN: no effect.
- Comparison is full VLEN width. The operands already have the encoding removed upstream; no XOR key in this block.

Optional Feature:
- RSS_STATS_EN defined: adds outputs stat_calls_o, stat_rets_o and stat_viol_o, 32 bits each, saturating.
  - They count accepted calls, accepted returns, and violations (including those seen while en_i=0).
  - Cleared by rst_i only.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- ariane_pkg additions:
  - rss_state_e enum {RSS_RUN, RSS_FLUSH, RSS_CRASH}.
  - rss_event_t struct {call, ret, link, target}, used by the branch unit to drive this block.
  - RSS_DEPTH default constant.
- One natural sub-module: rss_lifo_mem, the circular storage with wp/cnt, push/pop/overwrite and registered top-of-stack.
  - Control FSM and compare logic stay in ret_shadow_stack.

Test Plan:
- Calls with link 0x80000104, 0x80000220, then returns to 0x80000220, 0x80000104:
  - depth_o goes 1,2,1,0; no mismatch_o; crash_o stays 0.
- Call with link 0x80000104, then return to 0x80000108 with en_i=1:
  - mismatch_o pulses exactly the cycle after the return; crash_o=1 and stays high.
  - A following call leaves depth_o unchanged.
  - crash_clr_i → crash_o=0, depth_o=0.
- 18 calls with DEPTH=16 (links 0x1000+4k):
  - depth_o=16, dropped_o=2.
  - 16 correct returns: no violation.
  - 2 further returns to any address: no violation, dropped_o back to 0.
  - Next return: underflow → mismatch_o.
- Same-cycle call (link 0x2000) and return (target equal to top 0x1000) at depth 3:
  - No violation; depth_o stays 3.
  - A following return to 0x2000 passes.
- flush_i at depth 5 with a return pending compare:
  - No mismatch_o; depth_o=0 next cycle.
  - The first return after the flush underflows and flags.
- Wrong return with en_i=0: no pulse, crash_o=0, depth_o decrements.
  - With RSS_STATS_EN, stat_viol_o=1.

Source files
------------

// File: rtl/ret_shadow_stack_pkg.sv
// Shared types and defaults for the return-address shadow stack.
package ret_shadow_stack_pkg;

  localparam int unsigned RSS_VLEN  = 64;
  localparam int unsigned RSS_DEPTH = 16;

  typedef enum logic [1:0] {
    RSS_RUN,
    RSS_FLUSH,
    RSS_CRASH
  } rss_state_e;

  typedef struct packed {
    logic                call;
    logic                ret;
    logic [RSS_VLEN-1:0] link;
    logic [RSS_VLEN-1:0] target;
  } rss_event_t;

endpackage

// File: rtl/ret_shadow_stack_lifo_mem.sv
// Circular LIFO storage: push/pop/overwrite-oldest with a registered top-of-stack.
module rss_lifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned VLEN  = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN-1:0] top_o,
  output logic [CW-1:0]   cnt_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] top_q;
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   wp_m1;
  logic [AW-1:0]   wp_m2;
  logic [CW-1:0]   cnt_q;

  assign wp_m1   = wp_q - AW'(1);
  assign wp_m2   = wp_q - AW'(2);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign top_o   = top_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else if (push_i && !pop_i) begin
      wp_q <= wp_q + AW'(1);
      if (!full_o) cnt_q <= cnt_q + CW'(1);
    end else if (pop_i && !push_i) begin
      wp_q  <= wp_m1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Pop+push replaces the top slot in place; a push when full overwrites the oldest.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      if (push_i && pop_i) mem_q[wp_m1] <= data_i;
      else if (push_i)     mem_q[wp_q]  <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       top_q <= '0;
    else if (push_i) top_q <= data_i;
    else if (pop_i)  top_q <= mem_q[wp_m2];
  end

endmodule

// File: rtl/ret_shadow_stack.sv
// Shadow return-address stack with sticky crash request.
// Optional RSS_STATS_EN adds saturating call/return/violation counters.
module ret_shadow_stack
  import ret_shadow_stack_pkg::*;
#(
  parameter int unsigned DEPTH  = RSS_DEPTH,
  parameter int unsigned VLEN   = RSS_VLEN,
  parameter int unsigned DROP_W = 8,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              call_valid_i,
  input  logic [VLEN-1:0]   call_link_i,
  input  logic              ret_valid_i,
  input  logic [VLEN-1:0]   ret_target_i,
  input  logic              crash_clr_i,
  output logic              mismatch_o,
  output logic              crash_o,
  output logic [CW-1:0]     depth_o,
  output logic [DROP_W-1:0] dropped_o
`ifdef RSS_STATS_EN
  ,
  output logic [31:0]       stat_calls_o,
  output logic [31:0]       stat_rets_o,
  output logic [31:0]       stat_viol_o
`endif
);

  rss_state_e        state_q, state_d;
  logic              mis_q;
  logic [DROP_W-1:0] dropped_q;

  logic [VLEN-1:0]   top;
  logic [CW-1:0]     cnt;
  logic              full, empty;
  logic              accept, do_call, do_ret, pop, clear;
  logic              viol, drop_inc, drop_dec;

  assign accept   = (state_q == RSS_RUN) && !flush_i;
  assign do_call  = accept && call_valid_i;
  assign do_ret   = accept && ret_valid_i;
  assign pop      = do_ret && !empty;
  assign clear    = ((state_q == RSS_RUN) && flush_i) ||
                    ((state_q == RSS_CRASH) && crash_clr_i);
  // Empty stack: returns first unwind dropped entries unchecked, then underflow.
  assign viol     = do_ret && (empty ? (dropped_q == '0) : (ret_target_i != top));
  assign drop_dec = do_ret && empty && (dropped_q != '0);
  assign drop_inc = do_call && full && !do_ret;

  rss_lifo_mem #(
    .DEPTH(DEPTH),
    .VLEN (VLEN)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear),
    .push_i (do_call),
    .pop_i  (pop),
    .data_i (call_link_i),
    .top_o  (top),
    .cnt_o  (cnt),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RSS_RUN: begin
        if (flush_i)           state_d = RSS_FLUSH;
        else if (viol && en_i) state_d = RSS_CRASH;
      end
      RSS_FLUSH: state_d = RSS_RUN;
      RSS_CRASH: if (crash_clr_i) state_d = RSS_RUN;
      default:   state_d = RSS_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RSS_RUN;
      mis_q     <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      mis_q   <= viol && en_i;
      if (clear)                                dropped_q <= '0;
      else if (drop_inc && (dropped_q != '1))   dropped_q <= dropped_q + DROP_W'(1);
      else if (drop_dec)                        dropped_q <= dropped_q - DROP_W'(1);
    end
  end

  assign mismatch_o = mis_q;
  assign crash_o    = (state_q == RSS_CRASH);
  assign depth_o    = cnt;
  assign dropped_o  = dropped_q;

`ifdef RSS_STATS_EN
  logic [31:0] calls_q, rets_q, viols_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      calls_q <= '0;
      rets_q  <= '0;
      viols_q <= '0;
    end else begin
      if (do_call && (calls_q != '1)) calls_q <= calls_q + 32'd1;
      if (do_ret  && (rets_q  != '1)) rets_q  <= rets_q  + 32'd1;
      if (viol    && (viols_q != '1)) viols_q <= viols_q + 32'd1;
    end
  end

  assign stat_calls_o = calls_q;
  assign stat_rets_o  = rets_q;
  assign stat_viol_o  = viols_q;
`endif

endmodule

// File: tb/tb_ret_shadow_stack.sv
// Scoreboard bench for ret_shadow_stack against a queue-based reference stack.
module tb_ret_shadow_stack;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    bit          call;
    logic [63:0] link;
    bit          ret;
    logic [63:0] tgt;
    bit          fl;
    bit          clr;
    bit          en;
    bit          rst;
  } stim_t;

  typedef struct {
    bit       mis;
    bit       crash;
    bit [4:0] depth;
    bit [7:0] drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, flush, call_valid, ret_valid, crash_clr;
  logic [63:0] call_link, ret_target;
  logic        mismatch_o, crash_o;
  logic [4:0]  depth_o;
  logic [7:0]  dropped_o;
`ifdef RSS_STATS_EN
  logic [31:0] stat_calls_o, stat_rets_o, stat_viol_o;
`endif

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [63:0] m_stk[$];
  int          m_drop  = 0;
  int          m_viol  = 0;
  bit          m_crash = 0;
  bit          m_fl    = 0;

  always #5 clk = ~clk;

  ret_shadow_stack #(
    .DEPTH (16),
    .VLEN  (64),
    .DROP_W(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .flush_i     (flush),
    .call_valid_i(call_valid),
    .call_link_i (call_link),
    .ret_valid_i (ret_valid),
    .ret_target_i(ret_target),
    .crash_clr_i (crash_clr),
    .mismatch_o  (mismatch_o),
    .crash_o     (crash_o),
    .depth_o     (depth_o),
    .dropped_o   (dropped_o)
`ifdef RSS_STATS_EN
    ,
    .stat_calls_o(stat_calls_o),
    .stat_rets_o (stat_rets_o),
    .stat_viol_o (stat_viol_o)
`endif
  );

  function automatic stim_t ev(bit c, logic [63:0] l, bit r, logic [63:0] t,
                               bit fl = 0, bit clr = 0, bit e = 1, bit rs = 0);
    stim_t s;
    s.call = c; s.link = l; s.ret = r; s.tgt = t;
    s.fl = fl; s.clr = clr; s.en = e; s.rst = rs;
    return s;
  endfunction

  // Applies one cycle of stimulus, advances the reference model, queues its expectation.
  task automatic drive(input stim_t s);
    exp_t e;
    bit   v;
    e.mis = 0;
    if (s.rst) begin
      m_stk.delete(); m_drop = 0; m_viol = 0; m_crash = 0; m_fl = 0;
    end else if (m_fl) begin
      m_fl = 0;
    end else if (m_crash) begin
      if (s.clr) begin m_stk.delete(); m_drop = 0; m_crash = 0; end
    end else if (s.fl) begin
      m_stk.delete(); m_drop = 0; m_fl = 1;
    end else begin
      v = 0;
      if (s.ret) begin
        if (m_stk.size() > 0) begin
          v = (m_stk[$] != s.tgt);
          void'(m_stk.pop_back());
        end else if (m_drop > 0) m_drop--;
        else v = 1;
      end
      if (s.call) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          if (m_drop < 255) m_drop++;
        end
        m_stk.push_back(s.link);
      end
      if (v) m_viol++;
      if (v && s.en) begin e.mis = 1; m_crash = 1; end
    end
    e.crash = m_crash;
    e.depth = 5'(m_stk.size());
    e.drop  = 8'(m_drop);
    exp_q.push_back(e);
    rst = s.rst; en = s.en; flush = s.fl; crash_clr = s.clr;
    call_valid = s.call; call_link = s.link; ret_valid = s.ret; ret_target = s.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(ev(0, 0, 0, 0, 0, 0, 1, 1));
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL reset[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL reset[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL reset[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL reset[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_call_ret();
    stim_t t[$];
    exp_t  e;
    t.push_back(ev(1, 64'h80000104, 0, 0));
    t.push_back(ev(1, 64'h80000220, 0, 0));
    t.push_back(ev(0, 0, 0, 0, 0, 1));  // clear request while running
    t.push_back(ev(0, 0, 1, 64'h80000220));
    t.push_back(ev(0, 0, 1, 64'h80000104));
    t.push_back(ev(0, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL call_ret[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL call_ret[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL call_ret[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL call_ret[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_mismatch_crash();
    stim_t t[$];
    exp_t  e;
    t.push_back(ev(1, 64'h80000104, 0, 0));
    t.push_back(ev(0, 0, 1, 64'h80000108));
    t.push_back(ev(0, 0, 0, 0));
    t.push_back(ev(1, 64'h80000300, 0, 0));
    t.push_back(ev(0, 0, 1, 64'h80000300));
    t.push_back(ev(0, 0, 0, 0, 0, 1));
    t.push_back(ev(0, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL crash_seq[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL crash_seq[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL crash_seq[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL crash_seq[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_overflow();
    stim_t t[$];
    exp_t  e;
    for (int k = 0; k < 18; k++) t.push_back(ev(1, 64'h1000 + 64'(4 * k), 0, 0));
    for (int k = 17; k >= 2; k--) t.push_back(ev(0, 0, 1, 64'h1000 + 64'(4 * k)));
    t.push_back(ev(0, 0, 1, 64'hdead0000));
    t.push_back(ev(0, 0, 1, 64'hbeef0000));
    t.push_back(ev(0, 0, 1, 64'h1000));
    t.push_back(ev(0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL overflow[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL overflow[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL overflow[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL overflow[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_simultaneous();
    stim_t t[$];
    exp_t  e;
    t.push_back(ev(1, 64'h3000, 0, 0));
    t.push_back(ev(1, 64'h3004, 0, 0));
    t.push_back(ev(1, 64'h1000, 0, 0));
    t.push_back(ev(1, 64'h2000, 1, 64'h1000));
    t.push_back(ev(0, 0, 1, 64'h2000));
    t.push_back(ev(0, 0, 1, 64'h3004));
    t.push_back(ev(0, 0, 1, 64'h3000));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL simul[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL simul[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL simul[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL simul[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_flush();
    stim_t t[$];
    exp_t  e;
    for (int k = 0; k < 5; k++) t.push_back(ev(1, 64'h4000 + 64'(8 * k), 0, 0));
    t.push_back(ev(0, 0, 1, 64'h9999, 1));        // flush beats a wrong return
    t.push_back(ev(1, 64'h5000, 0, 0));           // ignored in the flush cycle
    t.push_back(ev(0, 0, 1, 64'h4020));           // underflow
    t.push_back(ev(0, 0, 0, 0, 0, 1));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL flush[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL flush[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL flush[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL flush[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
  endtask

  task automatic test_en_off();
    stim_t t[$];
    exp_t  e;
    t.push_back(ev(1, 64'h700, 0, 0));
    t.push_back(ev(0, 0, 1, 64'h704, 0, 0, 1, 1)); // reset wins over a wrong return
    t.push_back(ev(1, 64'h500, 0, 0, 0, 0, 0));
    t.push_back(ev(1, 64'h504, 0, 0, 0, 0, 0));
    t.push_back(ev(0, 0, 1, 64'h600, 0, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      total += 4;
      if (mismatch_o !== e.mis)  begin bad++; $display("FAIL en_off[%0d] mismatch got=%0b want=%0b", i, mismatch_o, e.mis); end
      if (crash_o !== e.crash)   begin bad++; $display("FAIL en_off[%0d] crash got=%0b want=%0b", i, crash_o, e.crash); end
      if (depth_o !== e.depth)   begin bad++; $display("FAIL en_off[%0d] depth got=%0d want=%0d", i, depth_o, e.depth); end
      if (dropped_o !== e.drop)  begin bad++; $display("FAIL en_off[%0d] dropped got=%0d want=%0d", i, dropped_o, e.drop); end
    end
`ifdef RSS_STATS_EN
    total++;
    if (stat_viol_o !== 32'(m_viol)) begin
      bad++; $display("FAIL stat_viol got=%0d want=%0d", stat_viol_o, m_viol);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_mismatch_crash();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_en_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
